// File: rtl/fmul_arbiter.sv
// Round-robin sequencer sharing one multi-cycle fp32 multiplier among NREQ requesters.
// One transaction in flight: accept, start pulse, wait for done or timeout, respond.
module fmul_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 64,
  parameter int IDW     = 3
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [31:0]       rsp_f,
  output logic              rsp_exc,
  output logic              rsp_tmo,
  output logic              mul_start,
  output logic [31:0]       mul_a,
  output logic [31:0]       mul_b,
  input  logic [31:0]       mul_f,
  input  logic              mul_exc,
  input  logic              mul_done,
  output logic              busy,
  output logic [IDW-1:0]    grant_id
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t          state;
  logic [IDW-1:0]  rr_ptr;
  logic [CW-1:0]   cnt;
  logic            live;
  logic            gnt_hit;
  logic [IDW-1:0]  gnt_idx;
  logic [NREQ-1:0] gid_oh;

  // Scan downward so the nearest requester at or after rr_ptr wins.
  always_comb begin
    gnt_hit = 1'b0;
    gnt_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      int j;
      j = (int'(rr_ptr) + k) % NREQ;
      if (req_valid[j]) begin
        gnt_hit = 1'b1;
        gnt_idx = IDW'(j);
      end
    end
  end

  always_comb begin
    gid_oh = '0;
    gid_oh[grant_id] = 1'b1;
  end

  // live keeps req_ready low while reset is held and for one cycle after.
  always_comb begin
    req_ready = '0;
    if (live && state == IDLE && gnt_hit)
      req_ready[gnt_idx] = 1'b1;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cnt       <= '0;
      live      <= 1'b0;
      grant_id  <= '0;
      rsp_valid <= '0;
      rsp_f     <= '0;
      rsp_exc   <= 1'b0;
      rsp_tmo   <= 1'b0;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
    end else begin
      live <= 1'b1;
      unique case (state)
        IDLE: begin
          if (live && gnt_hit) begin
            mul_a     <= req_a[int'(gnt_idx)*32 +: 32];
            mul_b     <= req_b[int'(gnt_idx)*32 +: 32];
            grant_id  <= gnt_idx;
            mul_start <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          mul_start <= 1'b0;
          cnt       <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          if (mul_done) begin
            rsp_f     <= mul_f;
            rsp_exc   <= mul_exc;
            rsp_tmo   <= 1'b0;
            rsp_valid <= gid_oh;
            state     <= RESP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            rsp_f     <= QNAN;
            rsp_exc   <= 1'b1;
            rsp_tmo   <= 1'b1;
            rsp_valid <= gid_oh;
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready[grant_id]) begin
            rsp_valid <= '0;
            rr_ptr    <= (grant_id == IDW'(NREQ - 1)) ?
                         '0 : grant_id + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fmul_arbiter.sv
// Directed bench for fmul_arbiter: reset, single, round-robin,
// exception, timeout, backpressure and mid-transaction reset.
module tb_fmul_arbiter;
  localparam int NREQ = 2;
  localparam int TMO  = 64;
  localparam int IDW  = 3;

  logic              clk = 1'b0;
  logic              clrn = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*32-1:0] req_a = '0;
  logic [NREQ*32-1:0] req_b = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready = '0;
  logic [31:0]       rsp_f;
  logic              rsp_exc;
  logic              rsp_tmo;
  logic              mul_start;
  logic [31:0]       mul_a;
  logic [31:0]       mul_b;
  logic [31:0]       mul_f = '0;
  logic              mul_exc = 1'b0;
  logic              mul_done = 1'b0;
  logic              busy;
  logic [IDW-1:0]    grant_id;

  int n_chk  = 0;
  int n_pass = 0;

  fmul_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO), .IDW(IDW)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_f     (rsp_f),
    .rsp_exc   (rsp_exc),
    .rsp_tmo   (rsp_tmo),
    .mul_start (mul_start),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_f     (mul_f),
    .mul_exc   (mul_exc),
    .mul_done  (mul_done),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic zeros(input string tag);
    check({tag, "_rdy"},  64'(req_ready), 0);
    check({tag, "_rspv"}, 64'(rsp_valid), 0);
    check({tag, "_f"},    64'(rsp_f), 0);
    check({tag, "_exc"},  64'(rsp_exc), 0);
    check({tag, "_tmo"},  64'(rsp_tmo), 0);
    check({tag, "_st"},   64'(mul_start), 0);
    check({tag, "_ma"},   64'(mul_a), 0);
    check({tag, "_mb"},   64'(mul_b), 0);
    check({tag, "_busy"}, 64'(busy), 0);
    check({tag, "_gid"},  64'(grant_id), 0);
  endtask

  task automatic do_reset();
    clrn = 1'b0;
    @(posedge clk); #1;
    clrn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wait_start(output int n);
    bit ok;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 20) begin
      @(negedge clk);
      n++;
      if (mul_start) ok = 1'b1;
    end
  endtask

  task automatic pulse_done(input logic [31:0] f, input logic e);
    @(posedge clk); #1;
    mul_done = 1'b1;
    mul_f    = f;
    mul_exc  = e;
    @(posedge clk); #1;
    mul_done = 1'b0;
  endtask

  task automatic take_rsp(input int id);
    rsp_ready = '0;
    rsp_ready[id] = 1'b1;
    @(posedge clk); #1;
    rsp_ready = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] f0;

    // reset with both requesting
    req_valid = 2'b11;
    @(posedge clk);
    @(negedge clk);
    zeros("rst");
    req_valid = 2'b00;
    @(posedge clk); #1;
    clrn = 1'b1;
    @(posedge clk); #1;

    // single request
    req_valid = 2'b01;
    req_a[31:0] = 32'h40F0_0000;
    req_b[31:0] = 32'h4178_0000;
    @(negedge clk);
    check("t2_rdy", 64'(req_ready), 1);
    wait_start(n);
    req_valid = 2'b00;
    check("t2_lat", n, 1);
    check("t2_ma", 64'(mul_a), 64'h40F0_0000);
    check("t2_mb", 64'(mul_b), 64'h4178_0000);
    check("t2_busy", 64'(busy), 1);
    check("t2_rdy0", 64'(req_ready), 0);
    @(negedge clk);
    check("t2_pulse", 64'(mul_start), 0);
    pulse_done(32'h42E8_8000, 1'b0);
    @(negedge clk);
    check("t2_rspv", 64'(rsp_valid), 1);
    check("t2_f", 64'(rsp_f), 64'h42E8_8000);
    check("t2_exc", 64'(rsp_exc), 0);
    check("t2_tmo", 64'(rsp_tmo), 0);
    take_rsp(0);
    @(negedge clk);
    check("t2_idle", 64'(busy), 0);
    check("t2_rspv0", 64'(rsp_valid), 0);

    // round-robin, both held valid
    do_reset();
    req_valid = 2'b11;
    req_a = {32'h4306_1000, 32'hC168_0000};
    req_b = {32'hC010_0000, 32'hBEC0_0000};
    for (int k = 0; k < 4; k++) begin
      int e;
      e = k % 2;
      @(negedge clk);
      check($sformatf("t3_rdy%0d", k), 64'(req_ready), 64'(1 << e));
      wait_start(n);
      check($sformatf("t3_gid%0d", k), 64'(grant_id), 64'(e));
      check($sformatf("t3_ma%0d", k), 64'(mul_a),
            e == 1 ? 64'h4306_1000 : 64'hC168_0000);
      f0 = (e == 1) ? 32'hC396_D200 : 32'h40AE_0000;
      pulse_done(f0, 1'b0);
      @(negedge clk);
      check($sformatf("t3_rspv%0d", k), 64'(rsp_valid), 64'(1 << e));
      check($sformatf("t3_f%0d", k), 64'(rsp_f), 64'(f0));
      take_rsp(e);
    end
    req_valid = 2'b00;

    // overflow exception from the multiplier
    req_a[31:0] = 32'h7F7F_FFFF;
    req_b[31:0] = 32'h7F7F_FFFF;
    req_valid = 2'b01;
    wait_start(n);
    req_valid = 2'b00;
    check("t4_start", 64'(mul_start), 1);
    pulse_done(32'h7F80_0000, 1'b1);
    @(negedge clk);
    check("t4_rspv", 64'(rsp_valid), 1);
    check("t4_f", 64'(rsp_f), 64'h7F80_0000);
    check("t4_exc", 64'(rsp_exc), 1);
    check("t4_tmo", 64'(rsp_tmo), 0);
    take_rsp(0);

    // timeout, then late and stray done pulses
    req_a[31:0] = 32'h3F80_0000;
    req_b[31:0] = 32'h4000_0000;
    req_valid = 2'b01;
    wait_start(n);
    req_valid = 2'b00;
    check("t5_start", 64'(mul_start), 1);
    n = 0;
    while (rsp_valid == '0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t5_lat", n, TMO + 1);
    check("t5_rspv", 64'(rsp_valid), 1);
    check("t5_f", 64'(rsp_f), 64'h7FC0_0000);
    check("t5_exc", 64'(rsp_exc), 1);
    check("t5_tmo", 64'(rsp_tmo), 1);
    pulse_done(32'h4000_0000, 1'b0);
    @(negedge clk);
    check("t5_late_f", 64'(rsp_f), 64'h7FC0_0000);
    check("t5_late_tmo", 64'(rsp_tmo), 1);
    check("t5_late_v", 64'(rsp_valid), 1);
    take_rsp(0);
    pulse_done(32'h4000_0000, 1'b0);
    @(negedge clk);
    check("t5_stray_busy", 64'(busy), 0);
    check("t5_stray_v", 64'(rsp_valid), 0);

    // backpressure on requester 1, wrong-index ready ignored
    req_a[63:32] = 32'h4040_0000;
    req_b[63:32] = 32'h4080_0000;
    req_valid = 2'b10;
    wait_start(n);
    check("t6_gid", 64'(grant_id), 1);
    req_valid = 2'b01;
    req_a[31:0] = 32'h3FC0_0000;
    req_b[31:0] = 32'h3FC0_0000;
    pulse_done(32'h4140_0000, 1'b0);
    rsp_ready = 2'b01;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("t6_v%0d", c), 64'(rsp_valid), 2);
      check($sformatf("t6_f%0d", c), 64'(rsp_f), 64'h4140_0000);
      check($sformatf("t6_rdy%0d", c), 64'(req_ready), 0);
    end
    rsp_ready = 2'b00;
    take_rsp(1);
    wait_start(n);
    check("t6_next_ma", 64'(mul_a), 64'h3FC0_0000);
    req_valid = 2'b00;
    @(negedge clk);
    check("t6_wait_busy", 64'(busy), 1);
    clrn = 1'b0;
    #1;
    zeros("t6_rst");
    @(posedge clk); #1;
    clrn = 1'b1;
    req_valid = 2'b01;
    @(posedge clk); #1;
    @(negedge clk);
    check("t6_post_rdy", 64'(req_ready), 1);
    req_valid = 2'b00;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
